// File: rtl/divider_unit.sv
// Sequential restoring divider: one quotient bit per clock, divisor loaded separately from the dividend.
// Define SIGNED_DIV_EN for two's-complement operands (adds PRE/POST sign-handling states).
module divider_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_B,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic [WIDTH-1:0] Dval,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CALC = 3'd2,
    S_POST = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [CW-1:0]    count;
  logic             dz_reg;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   trial;
  logic             last_iter;

  // Handshake: Run is a level; one Run assertion in IDLE yields exactly one
  // division, and the result is held (Done=1) until Run is observed low.
`ifdef SIGNED_DIV_EN
  logic [WIDTH-1:0] d_mag;
  logic             neg_q, neg_r;
  assign divisor = d_mag;
`else
  assign divisor = d_reg;
`endif

  // R < divisor is invariant, so bit WIDTH of the difference is a clean borrow.
  assign trial     = {r_reg, q_reg[WIDTH-1]} - {1'b0, divisor};
  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!Load_B && Run) begin
`ifdef SIGNED_DIV_EN
          state_n = S_PRE;
`else
          state_n = S_CALC;
`endif
        end
      end
      S_PRE: begin
        Busy    = 1'b1;
        state_n = (d_reg == '0) ? S_HOLD : S_CALC;
      end
      S_CALC: begin
        Busy = 1'b1;
`ifdef SIGNED_DIV_EN
        if (last_iter) state_n = S_POST;
`else
        if (d_reg == '0 || last_iter) state_n = S_HOLD;
`endif
      end
      S_POST: begin
        Busy    = 1'b1;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        Done = 1'b1;
        if (!Run) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_reg  <= '0;
      r_reg  <= '0;
      d_reg  <= '0;
      count  <= '0;
      dz_reg <= 1'b0;
`ifdef SIGNED_DIV_EN
      d_mag  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Load_B) begin
            d_reg <= Din;
          end else if (Run) begin
            q_reg <= Din;
            r_reg <= '0;
            count <= '0;
          end
        end
`ifdef SIGNED_DIV_EN
        S_PRE: begin
          if (d_reg == '0) begin
            r_reg  <= q_reg;
            q_reg  <= '1;
            dz_reg <= 1'b1;
          end else begin
            neg_q <= q_reg[WIDTH-1] ^ d_reg[WIDTH-1];
            neg_r <= q_reg[WIDTH-1];
            q_reg <= q_reg[WIDTH-1] ? (~q_reg + 1'b1) : q_reg;
            d_mag <= d_reg[WIDTH-1] ? (~d_reg + 1'b1) : d_reg;
          end
        end
        S_POST: begin
          if (neg_q) q_reg <= ~q_reg + 1'b1;
          if (neg_r) r_reg <= ~r_reg + 1'b1;
        end
`endif
        S_CALC: begin
`ifndef SIGNED_DIV_EN
          if (d_reg == '0) begin
            r_reg  <= q_reg;
            q_reg  <= '1;
            dz_reg <= 1'b1;
          end else
`endif
          begin
            if (!trial[WIDTH]) begin
              r_reg <= trial[WIDTH-1:0];
              q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
              r_reg <= {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
              q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
          end
        end
        S_HOLD: begin
          if (!Run) dz_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Qval      = q_reg;
  assign Rval      = r_reg;
  assign Dval      = d_reg;
  assign Div_Zero  = dz_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit (WIDTH=8): vector table plus hold/reset/load corner sequences.
module tb_divider_unit;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 3;
  localparam int PRE = 1;
`else
  localparam int LAT = W + 1;
  localparam int PRE = 0;
`endif
  localparam int ZLAT = 2;

  logic         Clk = 1'b0;
  logic         Reset, Load_B, Run;
  logic [W-1:0] Din;
  logic [W-1:0] Qval, Rval, Dval;
  logic         Busy, Done, Div_Zero;
  logic [2:0]   dbg_state;

  divider_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Load_B(Load_B), .Run(Run), .Din(Din),
    .Qval(Qval), .Rval(Rval), .Dval(Dval),
    .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All driver tasks enter and leave at a falling edge.
  task automatic load_d(input logic [W-1:0] d);
    Load_B = 1'b1;
    Din    = d;
    @(negedge Clk);
    Load_B = 1'b0;
  endtask

  // Raises Run with dividend n and counts clocks until Done; Run stays high.
  task automatic start_div(input logic [W-1:0] n, output int lat);
    Din = n;
    Run = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      Din    = W'($urandom_range(0, 255));
      Load_B = !Done && ($urandom_range(0, 1) == 1);
    end while (!Done && lat < 100);
    Load_B = 1'b0;
    if (lat >= 100) check("done_timeout", 0, 1);
  endtask

  task automatic release_run();
    Run = 1'b0;
    @(negedge Clk);
    check("idle_done", Done, 0);
    check("idle_dz", Div_Zero, 0);
    check("idle_state", dbg_state, 0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] q0, r0;
`ifdef SIGNED_DIV_EN
    vecs[0] = '{8'h07, 8'h9C, 8'hF2, 8'hFE, 1'b0};
    vecs[1] = '{8'hFF, 8'h80, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'h05, 8'hFF, 8'h05, 1'b1};
    vecs[3] = '{8'h0A, 8'h64, 8'h0A, 8'h00, 1'b0};
    vecs[4] = '{8'hF9, 8'h64, 8'hF2, 8'h02, 1'b0};
    vecs[5] = '{8'h02, 8'h07, 8'h03, 8'h01, 1'b0};
    vecs[6] = '{8'hFE, 8'hF9, 8'h03, 8'hFF, 1'b0};
    vecs[7] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0};
`else
    vecs[0] = '{8'h07, 8'hC8, 8'h1C, 8'h04, 1'b0};
    vecs[1] = '{8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 8'hFE, 8'h00, 8'hFE, 1'b0};
    vecs[3] = '{8'h00, 8'h05, 8'hFF, 8'h05, 1'b1};
    vecs[4] = '{8'h0A, 8'h64, 8'h0A, 8'h00, 1'b0};
    vecs[5] = '{8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'h10, 8'hFF, 8'h0F, 8'h0F, 1'b0};
    vecs[7] = '{8'h02, 8'h81, 8'h40, 8'h01, 1'b0};
`endif

    Reset = 1'b1; Load_B = 1'b0; Run = 1'b0; Din = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst_q", Qval, 0);
    check("rst_r", Rval, 0);
    check("rst_d", Dval, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dz", Div_Zero, 0);
    check("rst_state", dbg_state, 0);

    for (int i = 0; i < 8; i++) begin
      load_d(vecs[i].d);
      check("load_d", Dval, vecs[i].d);
      exp_q.push_back(vecs[i].q);
      exp_q.push_back(vecs[i].r);
      start_div(vecs[i].n, lat);
      check("vec_q", Qval, exp_q.pop_front());
      check("vec_r", Rval, exp_q.pop_front());
      check("vec_dz", Div_Zero, vecs[i].dz);
      check("vec_lat", lat, vecs[i].dz ? ZLAT : LAT);
      check("vec_d_kept", Dval, vecs[i].d);
      check("vec_busy", Busy, 0);
      release_run();
    end

    // Run held high after Done: result frozen, no restart.
    load_d(8'h07);
    start_div(8'h64, lat);
    q0 = Qval;
    r0 = Rval;
    check("hold_q0", q0, 8'h0E);
    check("hold_r0", r0, 8'h02);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Done !== 1'b1 || Qval !== q0 || Rval !== r0 || Busy !== 1'b0)
        check("hold_stable", {Done, Busy, Qval, Rval}, {2'b10, q0, r0});
    end
    check("hold_done", Done, 1);
    release_run();
    start_div(8'h15, lat);
    check("repress_q", Qval, 8'h03);
    check("repress_r", Rval, 8'h00);
    release_run();

    // Reset in the middle of CALC (count=3).
    load_d(8'h07);
    Din = 8'h64;
    Run = 1'b1;
    repeat (4 + PRE) @(negedge Clk);
    check("mid_busy", Busy, 1);
    Reset = 1'b1;
    Run   = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_q", Qval, 0);
    check("midrst_r", Rval, 0);
    check("midrst_d", Dval, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_state", dbg_state, 0);

    // Load_B and Run together in IDLE: only the divisor loads.
    Load_B = 1'b1;
    Run    = 1'b1;
    Din    = 8'h33;
    @(negedge Clk);
    Load_B = 1'b0;
    Run    = 1'b0;
    check("both_d", Dval, 8'h33);
    check("both_busy", Busy, 0);
    check("both_state", dbg_state, 0);
    check("both_q", Qval, 0);
    @(negedge Clk);
    check("both_idle", dbg_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
